// File: rtl/multi_period_meter_pkg.sv
// Shared types and sizing helpers for the multi-channel period meter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package multi_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STALLED = 2'd2
    } ch_state_t;

    // Each period fits in cnt_w bits, so summing 2^avg_log2 of them needs avg_log2 extra bits.
    function automatic int acc_width(input int cnt_w, input int avg_log2);
        return cnt_w + avg_log2;
    endfunction

    function automatic int idx_width(input int avg_log2);
        return (avg_log2 > 0) ? avg_log2 : 1;
    endfunction

endpackage

// File: rtl/multi_period_meter_ch.sv
// One channel: synchronise, detect rising edges, count clk cycles between them, average.
// Latency: input rise to edge_pulse is SYNC_STAGES+1 cycles; a result strobes with its closing edge.
// Backpressure: none; results are strobed once and the consumer must capture them.
module multi_period_meter_ch
    import multi_period_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             freq_in,
    output logic [CNT_W-1:0] period_out,
    output logic             out_valid,
    output logic             edge_pulse,
    output logic             stalled
);

    localparam int ACC_W = acc_width(CNT_W, AVG_LOG2);
    localparam int IDX_W = idx_width(AVG_LOG2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   edge_det;

    ch_state_t              state_q;
    ch_state_t              state_d;

    logic [CNT_W-1:0]       cnt_q;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       acc_sum;
    logic [IDX_W-1:0]       idx_q;
    logic                   take_period;
    logic                   period_done;
    logic                   cnt_run;
    logic                   hist_clr;

    // The synchroniser is deliberately left alone by clr so a level held across clr is not seen as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], freq_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    if (edge_det) state_d = ST_MEASURE;
                // An edge arriving on the saturating cycle is still a valid period.
                ST_MEASURE: if (!edge_det && cnt_q == CNT_MAX) state_d = ST_STALLED;
                ST_STALLED: if (edge_det) state_d = ST_MEASURE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        take_period = edge_det && (state_q == ST_MEASURE);
        cnt_run     = (state_q == ST_MEASURE) && (cnt_q != CNT_MAX);
        hist_clr    = (state_d == ST_STALLED);
        stalled     = (state_q == ST_STALLED);
    end

    assign acc_sum     = acc_q + ACC_W'(cnt_q);
    assign period_done = (AVG_LOG2 == 0) || (idx_q == {IDX_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            period_out <= '0;
            out_valid  <= 1'b0;
            edge_pulse <= 1'b0;
        end else if (clr) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            period_out <= '0;
            out_valid  <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            edge_pulse <= edge_det;
            out_valid  <= 1'b0;

            if (edge_det) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_run) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (take_period) begin
                if (period_done) begin
                    period_out <= acc_sum[AVG_LOG2 +: CNT_W];
                    out_valid  <= 1'b1;
                    acc_q      <= '0;
                    idx_q      <= '0;
                end else begin
                    acc_q      <= acc_sum;
                    idx_q      <= idx_q + IDX_W'(1);
                end
            end else if (hist_clr) begin
                acc_q <= '0;
                idx_q <= '0;
            end
        end
    end

endmodule

// File: rtl/multi_period_meter.sv
// Multi-channel period meter: NUM_CH independent channels with packed result outputs.
// Latency: input rise to edge_pulse is SYNC_STAGES+1 cycles; results strobe with the closing edge.
// Backpressure: none; out_valid is a single-cycle strobe per channel.
module multi_period_meter
    import multi_period_meter_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       freq_in,
    input  logic                    clr,
    output logic [NUM_CH*CNT_W-1:0] period_out,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [NUM_CH-1:0]       edge_pulse,
    output logic [NUM_CH-1:0]       stalled
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        multi_period_meter_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .AVG_LOG2    (AVG_LOG2)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .freq_in    (freq_in[g]),
            .period_out (period_out[g*CNT_W +: CNT_W]),
            .out_valid  (out_valid[g]),
            .edge_pulse (edge_pulse[g]),
            .stalled    (stalled[g])
        );
    end

endmodule
